// File: rtl/dlyd_meas_pkg.sv
// Shared types and constants for the dlyd delay-chain measurement controller.
package dlyd_meas_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    FIRE  = 3'd2,
    WAIT  = 3'd3,
    FIN   = 3'd4,
    ABORT = 3'd5
  } state_t;

  localparam int SYNC_STAGES  = 2;
  // Per-edge count seen with ARRIVE tied straight to LAUNCH.
  localparam int LOOPBACK_CNT = 2;

endpackage

// File: rtl/dlyd_meas_sync2.sv
// Flop-chain synchronizer bringing the far end of the delay chain into CLK.
module dlyd_meas_sync2
  import dlyd_meas_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlyd_meas.sv
// Launches alternating edges into an external delay chain and averages the
// synchronized round-trip time, in CLK cycles, over 2^AVG_LOG2 edges.
module gf180mcu_fd_sc_mcu7t5v0__dlyd_meas
  import dlyd_meas_pkg::*;
#(
  parameter int CNT_W    = 12,
  parameter int AVG_LOG2 = 2,
  parameter int TMO_CYC  = 4000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ARRIVE,
  output logic             LAUNCH,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] RESULT,
  output logic             TIMEOUT,
  output state_t           o_dbg_state,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int EDGE_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0]  TMO_FULL  = CNT_W'(TMO_CYC);

  state_t            r_state;
  logic              r_launch;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_result;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_cnt;
  logic [EDGE_W-1:0] r_edge_idx;
  logic [ACC_W-1:0]  r_acc;

  logic             w_arrive_s;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_unused_supply;

  dlyd_meas_sync2 #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk(CLK),
    .i_rst(RST),
    .i_d  (ARRIVE),
    .o_q  (w_arrive_s)
  );

  // The chain has delivered the current launch level back to us.
  assign w_match   = (w_arrive_s == r_launch);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_launch   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_timeout  <= 1'b0;
      r_cnt      <= '0;
      r_edge_idx <= '0;
      r_acc      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (START) begin
            r_state    <= ARM;
            r_busy     <= 1'b1;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
            r_edge_idx <= '0;
            r_acc      <= '0;
          end
        end
        ARM: begin
          if (w_match) begin
            r_state  <= FIRE;
            r_launch <= ~r_launch;
            r_cnt    <= '0;
          end else if (w_cnt_inc == TMO_FULL) begin
            r_state <= ABORT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        FIRE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= w_cnt_inc;
          // Arrival is checked first so a match on the last count still wins.
          if (w_match) begin
            r_acc      <= r_acc + ACC_W'(w_cnt_inc);
            r_edge_idx <= r_edge_idx + EDGE_W'(1);
            if (r_edge_idx == EDGE_LAST) begin
              r_state <= FIN;
            end else begin
              r_state  <= FIRE;
              r_launch <= ~r_launch;
            end
          end else if (w_cnt_inc == TMO_LAST) begin
            r_state <= ABORT;
          end
        end
        FIN: begin
          r_result <= CNT_W'(r_acc >> AVG_LOG2);
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        ABORT: begin
          r_result  <= '1;
          r_timeout <= 1'b1;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_unused_supply = VDD ^ VSS;

  assign LAUNCH      = r_launch;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign RESULT      = r_result;
  assign TIMEOUT     = r_timeout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dlyd_meas.sv
// Directed bench: two controllers (1-edge and 2-edge averaging) driving
// behavioural delay chains, with a result scoreboard fed at START.
module tb_gf180mcu_fd_sc_mcu7t5v0__dlyd_meas;
  import dlyd_meas_pkg::*;

  localparam int CNT_W = 12;
  localparam int TMO   = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start_a, start_b;
  logic arrive_a, arrive_b;
  wire  launch_a, busy_a, done_a, timeout_a;
  wire  launch_b, busy_b, done_b, timeout_b;
  wire  [CNT_W-1:0] result_a, result_b;
  wire  [2:0] dbg_a, dbg_b;
  wire  vdd, vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  gf180mcu_fd_sc_mcu7t5v0__dlyd_meas #(.CNT_W(CNT_W), .AVG_LOG2(0), .TMO_CYC(TMO)) u_dut_a (
    .CLK(clk), .RST(rst), .START(start_a), .ARRIVE(arrive_a), .LAUNCH(launch_a),
    .BUSY(busy_a), .DONE(done_a), .RESULT(result_a), .TIMEOUT(timeout_a),
    .o_dbg_state(dbg_a), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu7t5v0__dlyd_meas #(.CNT_W(CNT_W), .AVG_LOG2(1), .TMO_CYC(TMO)) u_dut_b (
    .CLK(clk), .RST(rst), .START(start_b), .ARRIVE(arrive_b), .LAUNCH(launch_b),
    .BUSY(busy_b), .DONE(done_b), .RESULT(result_b), .TIMEOUT(timeout_b),
    .o_dbg_state(dbg_b), .VDD(vdd), .VSS(vss)
  );

  // Behavioural chains: lnq[k] carries LAUNCH delayed by k+1 clock periods.
  logic [15:0] lnq_a, lnq_b;
  logic        stuck_a;
  logic [4:0]  dly_a, rise_b, fall_b;

  always @(posedge clk) begin
    if (rst) begin
      lnq_a <= '0;
      lnq_b <= '0;
    end else begin
      lnq_a <= {lnq_a[14:0], launch_a};
      lnq_b <= {lnq_b[14:0], launch_b};
    end
  end

  always_comb begin
    arrive_a = 1'b0;
    if (!stuck_a) arrive_a = (dly_a == 5'd0) ? launch_a : lnq_a[dly_a - 5'd1];
  end

  // OR of two taps gives a rise delay of rise_b and a fall delay of fall_b (rise_b <= fall_b).
  always_comb begin
    arrive_b = launch_b;
    if (rise_b != 5'd0) arrive_b = lnq_b[rise_b - 5'd1] | lnq_b[fall_b - 5'd1];
  end

  // scoreboard
  logic [CNT_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_pulse(input bit sel, input logic [CNT_W-1:0] exp);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check("busy_after_start", sel ? busy_b : busy_a, 1);
  endtask

  // mode 0: START low, 1: toggle START while busy, 2: leave START as driven.
  task automatic wait_done(input bit sel, input int mode, output int cyc);
    bit got;
    logic [CNT_W-1:0] res;
    logic [CNT_W-1:0] exp;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if ((sel ? done_b : done_a) === 1'b1) begin
        got = 1'b1;
        if (mode != 2) begin
          start_a = 1'b0;
          start_b = 1'b0;
        end
        res = sel ? result_b : result_a;
        check("sb_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check("sb_result", res, exp);
        end
        check("busy_low_at_done", sel ? busy_b : busy_a, 0);
      end else if (mode == 1) begin
        if (sel) start_b = cyc[0]; else start_a = cyc[0];
      end
    end
    check("done_seen", got, 1);
  endtask

  task automatic count_done(input int n, output int nd);
    nd = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) nd++;
    end
  endtask

  int cyc;
  int nd;

  initial begin
    start_a = 1'b0;
    start_b = 1'b0;
    stuck_a = 1'b0;
    dly_a   = 5'd0;
    rise_b  = 5'd0;
    fall_b  = 5'd0;
    repeat (3) @(negedge clk);

    check("rst_launch", launch_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_result", result_a, 0);
    check("rst_timeout", timeout_a, 0);
    check("rst_state", dbg_a, 32'(IDLE));
    check("rst_result_b", result_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // loopback, single edge
    start_pulse(0, CNT_W'(LOOPBACK_CNT));
    wait_done(0, 0, cyc);
    check("loop_latency", cyc, 5);
    check("loop_timeout", timeout_a, 0);
    check("loop_launch", launch_a, 1);
    @(negedge clk);
    check("done_one_cycle", done_a, 0);

    // stuck chain: first edge times out, next START clears TIMEOUT
    do_reset();
    stuck_a = 1'b1;
    start_pulse(0, 12'hFFF);
    wait_done(0, 0, cyc);
    check("stuck_timeout", timeout_a, 1);
    check("stuck_launch", launch_a, 1);
    start_pulse(0, 12'hFFF);
    check("timeout_cleared", timeout_a, 0);
    wait_done(0, 0, cyc);
    check("stuck_arm_timeout", timeout_a, 1);
    stuck_a = 1'b0;

    // START toggled while busy
    do_reset();
    start_pulse(0, CNT_W'(LOOPBACK_CNT));
    wait_done(0, 1, cyc);
    check("jitter_latency", cyc, 5);
    count_done(12, nd);
    check("no_extra_done", nd, 0);

    // reset in WAIT aborts silently
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("state_wait", dbg_a, 32'(WAIT));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_launch", launch_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_result", result_a, 0);
    check("midrst_done", done_a, 0);
    count_done(8, nd);
    check("midrst_no_done", nd, 0);
    start_pulse(0, CNT_W'(LOOPBACK_CNT));
    wait_done(0, 0, cyc);
    check("post_rst_latency", cyc, 5);

    // START held high re-triggers right after DONE
    start_a = 1'b1;
    exp_q.push_back(CNT_W'(LOOPBACK_CNT));
    @(negedge clk);
    wait_done(0, 2, cyc);
    exp_q.push_back(CNT_W'(LOOPBACK_CNT));
    @(negedge clk);
    start_a = 1'b0;
    check("retrigger_busy", busy_a, 1);
    wait_done(0, 0, cyc);
    check("retrigger_latency", cyc, 5);

    // arrival coincident with the last count is not a timeout
    dly_a = 5'd13;
    do_reset();
    start_pulse(0, CNT_W'(TMO - 1));
    wait_done(0, 0, cyc);
    check("edge_tmo_timeout", timeout_a, 0);

    // one cycle more of chain delay does time out
    dly_a = 5'd14;
    do_reset();
    start_pulse(0, 12'hFFF);
    wait_done(0, 0, cyc);
    check("over_tmo_timeout", timeout_a, 1);

    // two-edge average: loopback, then 7-rise / 9-fall chain
    do_reset();
    start_pulse(1, CNT_W'(LOOPBACK_CNT));
    wait_done(1, 0, cyc);
    check("b_loop_launch", launch_b, 0);
    rise_b = 5'd7;
    fall_b = 5'd9;
    do_reset();
    start_pulse(1, CNT_W'((9 + 11) >> 1));
    wait_done(1, 0, cyc);
    check("chain_launch", launch_b, 0);
    check("chain_timeout", timeout_b, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
